// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle control step sequencer for the 32-bit datapath
// Fetch T0-T2, decode in T3, execute T3-T7. Moore outputs from state plus the live IR opcode.
module control_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 5,
  parameter logic [OP_WIDTH-1:0] ALU_ADD = 5'b00011
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] registerIR,
  output logic                  run,
  output logic                  PCout,
  output logic                  IncPC,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  Zlo_out,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  Yin,
  output logic                  Cout,
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Mem_enable512x32,
  output logic [OP_WIDTH-1:0]   opcode
);

  localparam logic [OP_WIDTH-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_WIDTH-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_WIDTH-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_WIDTH-1:0] OP_ADDI = 5'b00011;
  localparam logic [OP_WIDTH-1:0] OP_ORI  = 5'b01010;
  localparam logic [OP_WIDTH-1:0] OP_ANDI = 5'b01011;
  localparam logic [OP_WIDTH-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_WIDTH-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [OP_WIDTH-1:0] op;
  logic                is_alu_imm;
  logic                is_ldi;
  logic                is_mem;
  logic                unused_ir;

  // Decode is combinational on the IR, so it is only meaningful from T3 on.
  assign op         = registerIR[DATA_WIDTH-1 -: OP_WIDTH];
  assign is_alu_imm = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_ANDI);
  assign is_ldi     = (op == OP_LDI);
  assign is_mem     = (op == OP_LD) || (op == OP_ST);
  assign unused_ir  = ^registerIR[DATA_WIDTH-OP_WIDTH-1:0];

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_alu_imm || is_ldi || is_mem) state_d = S_T4;
        else if (op == OP_HALT)             state_d = S_HALT;
        else                                state_d = S_T0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_mem ? S_T6 : S_T0;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run = 1'b0;
    PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; Zin = 1'b0; Zlo_out = 1'b0;
    PCin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Yin = 1'b0; Cout = 1'b0; HIout = 1'b0; LOout = 1'b0;
    Mem_Read = 1'b0; Mem_Write = 1'b0; Mem_enable512x32 = 1'b0;
    opcode = '0;
    case (state_q)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Zlo_out = 1'b1; PCin = 1'b1; Mem_Read = 1'b1;
        Mem_enable512x32 = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (is_alu_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (op == OP_MFHI) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op == OP_MFLO) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1; Cout = 1'b1; Zin = 1'b1;
        opcode = is_alu_imm ? op : ALU_ADD;
      end
      S_T5: begin
        run = 1'b1; Zlo_out = 1'b1;
        if (is_mem) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        run = 1'b1; MDRin = 1'b1;
        if (op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1;
        end else begin
          Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (op == OP_ST) begin
          Mem_Write = 1'b1; Mem_enable512x32 = 1'b1;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench for control_sequencer
module tb_control_sequencer;

  logic        Clock;
  logic        clear;
  logic        start;
  logic [31:0] registerIR;
  logic run, PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin;
  logic Gra, Grb, Rin, Rout, BAout, Yin, Cout, HIout, LOout;
  logic Mem_Read, Mem_Write, Mem_enable512x32;
  logic [4:0] opcode;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .registerIR(registerIR),
    .run(run), .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin),
    .Zlo_out(Zlo_out), .PCin(PCin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Yin(Yin),
    .Cout(Cout), .HIout(HIout), .LOout(LOout), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32), .opcode(opcode)
  );

  localparam logic [26:0] RUN = 27'd1 << 26, PCO = 27'd1 << 25, INC = 27'd1 << 24;
  localparam logic [26:0] MAR = 27'd1 << 23, ZIN = 27'd1 << 22, ZLO = 27'd1 << 21;
  localparam logic [26:0] PCI = 27'd1 << 20, MDI = 27'd1 << 19, MDO = 27'd1 << 18;
  localparam logic [26:0] IRI = 27'd1 << 17, GRA = 27'd1 << 16, GRB = 27'd1 << 15;
  localparam logic [26:0] RIN = 27'd1 << 14, ROU = 27'd1 << 13, BAO = 27'd1 << 12;
  localparam logic [26:0] YIN = 27'd1 << 11, COU = 27'd1 << 10, HIO = 27'd1 << 9;
  localparam logic [26:0] LOO = 27'd1 << 8, MRD = 27'd1 << 7, MWR = 27'd1 << 6;
  localparam logic [26:0] MEN = 27'd1 << 5;

  localparam logic [26:0] F0 = RUN | PCO | INC | MAR | ZIN;
  localparam logic [26:0] F1 = RUN | ZLO | PCI | MRD | MEN | MDI;
  localparam logic [26:0] F2 = RUN | MDO | IRI;
  localparam logic [26:0] EA3 = RUN | GRB | BAO | YIN;
  localparam logic [26:0] ADD4 = RUN | COU | ZIN | 27'd3;

  logic [26:0] vec;
  assign vec = {run, PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin,
                Gra, Grb, Rin, Rout, BAout, Yin, Cout, HIout, LOout,
                Mem_Read, Mem_Write, Mem_enable512x32, opcode};

  int total = 0;
  int bad = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [26:0] got, input logic [26:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [26:0] exp);
    @(posedge Clock);
    @(negedge Clock);
    check_eq(tag, vec, exp);
  endtask

  initial begin
    clear = 1'b0;
    start = 1'b0;
    registerIR = 32'h0;
    #1 clear = 1'b1;
    #1 check_eq("reset", vec, 27'd0);
    @(negedge Clock);
    clear = 1'b0;
    check_eq("idle", vec, 27'd0);

    registerIR = 32'h18900001;
    start = 1'b1;
    step("addi_t0", F0);
    start = 1'b0;
    step("addi_t1", F1);
    step("addi_t2", F2);
    step("addi_t3", RUN | GRB | ROU | YIN);
    step("addi_t4", RUN | COU | ZIN | 27'd3);
    step("addi_t5", RUN | ZLO | GRA | RIN);
    step("addi_next_t0", F0);

    registerIR = 32'h51000007;
    step("ori_t1", F1);
    step("ori_t2", F2);
    step("ori_t3", RUN | GRB | ROU | YIN);
    step("ori_t4", RUN | COU | ZIN | 27'd10);
    step("ori_t5", RUN | ZLO | GRA | RIN);
    step("ori_next_t0", F0);

    registerIR = 32'h08800010;
    step("ldi_t1", F1);
    step("ldi_t2", F2);
    step("ldi_t3", EA3);
    step("ldi_t4", ADD4);
    step("ldi_t5", RUN | ZLO | GRA | RIN);
    step("ldi_next_t0", F0);

    registerIR = 32'h00880005;
    step("ld_t1", F1);
    step("ld_t2", F2);
    step("ld_t3", EA3);
    step("ld_t4", ADD4);
    step("ld_t5", RUN | ZLO | MAR);
    step("ld_t6", RUN | MRD | MEN | MDI);
    step("ld_t7", RUN | MDO | GRA | RIN);
    step("ld_next_t0", F0);

    registerIR = 32'h10800004;
    step("st_t1", F1);
    step("st_t2", F2);
    step("st_t3", EA3);
    step("st_t4", ADD4);
    step("st_t5", RUN | ZLO | MAR);
    step("st_t6", RUN | GRA | ROU | MDI);
    step("st_t7", RUN | MWR | MEN);
    step("st_next_t0", F0);

    registerIR = 32'hC0800000;
    step("mfhi_t1", F1);
    step("mfhi_t2", F2);
    step("mfhi_t3", RUN | HIO | GRA | RIN);
    step("mfhi_next_t0", F0);

    registerIR = 32'hC8800000;
    step("mflo_t1", F1);
    step("mflo_t2", F2);
    step("mflo_t3", RUN | LOO | GRA | RIN);
    step("mflo_next_t0", F0);

    registerIR = 32'hD8000000;
    step("halt_t1", F1);
    step("halt_t2", F2);
    step("halt_t3", RUN);
    start = 1'b1;
    for (int i = 0; i < 10; i++) step("halt_hold", 27'd0);
    clear = 1'b1;
    #1 check_eq("halt_clear", vec, 27'd0);
    @(negedge Clock);
    clear = 1'b0;
    step("resume_t0", F0);
    start = 1'b0;

    registerIR = 32'h00880005;
    step("ld2_t1", F1);
    step("ld2_t2", F2);
    step("ld2_t3", EA3);
    step("ld2_t4", ADD4);
    step("ld2_t5", RUN | ZLO | MAR);
    step("ld2_t6", RUN | MRD | MEN | MDI);
    #2 clear = 1'b1;
    #1 check_eq("abort_clear", vec, 27'd0);
    @(negedge Clock);
    clear = 1'b0;
    step("abort_idle", 27'd0);

    registerIR = 32'hF8000000;
    start = 1'b1;
    step("nop_t0", F0);
    start = 1'b0;
    step("nop_t1", F1);
    step("nop_t2", F2);
    step("nop_t3", RUN);
    step("nop_next_t0", F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
